// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - deglitching receiver that recovers digit values from a multiplexed 7-segment bus
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   seg_in       segment lines {g,f,e,d,c,b,a}, bit 0 = a
//   dp_in        decimal point line
//   dig_en       digit enables, bit i = digit i
//   bcd_out      recovered value per digit, digit i at [4i+3:4i]
//   dp_out       captured decimal point per digit
//   digit_valid  last capture of digit i was a legal pattern
//   frame_valid  one-cycle pulse when every digit has been captured
//   err          one-cycle pulse on illegal pattern or multiple enables
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter bit COMMON_ANODE  = 1'b0,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    input  logic                      dp_in,
    input  logic [NUM_DIGITS-1:0]     dig_en,
    output logic [4*NUM_DIGITS-1:0]   bcd_out,
    output logic [NUM_DIGITS-1:0]     dp_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      frame_valid,
    output logic                      err
);

    localparam int                    SW  = 8 + NUM_DIGITS;
    localparam logic [7:0]            STB = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    // Everything downstream of this point works on active-high values.
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] en_n;
    logic [SW-1:0]         samp_in;

    assign seg_n   = COMMON_ANODE ? ~seg_in : seg_in;
    assign dp_n    = COMMON_ANODE ? ~dp_in  : dp_in;
    assign en_n    = COMMON_ANODE ? ~dig_en : dig_en;
    assign samp_in = {seg_n, dp_n, en_n};

    logic [SW-1:0]         samp;
    logic [7:0]            cnt;
    logic                  captured;
    logic [NUM_DIGITS-1:0] seen;

    logic [6:0]            samp_seg;
    logic                  samp_dp;
    logic [NUM_DIGITS-1:0] samp_en;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  capture;
    logic                  multi;

    assign samp_seg  = samp[SW-1 -: 7];
    assign samp_dp   = samp[NUM_DIGITS];
    assign samp_en   = samp[NUM_DIGITS-1:0];
    assign seen_next = seen | samp_en;

    // cnt counts how many consecutive samples samp has held its value, so
    // reaching STABLE_CYCLES means the window is complete; captured keeps a
    // long-held pattern from being captured more than once.
    assign capture = (cnt == STB) && !captured;
    assign multi   = (samp_en & (samp_en - ONE)) != '0;

    logic [3:0] dec_val;
    logic       dec_legal;
    logic       dec_blank;

    assign dec_blank = (samp_seg == 7'h00);

    always_comb begin
        dec_val   = 4'h0;
        dec_legal = 1'b1;
        case (samp_seg)
            7'h3F: dec_val = 4'h0;
            7'h06: dec_val = 4'h1;
            7'h5B: dec_val = 4'h2;
            7'h4F: dec_val = 4'h3;
            7'h66: dec_val = 4'h4;
            7'h6D: dec_val = 4'h5;
            7'h7D: dec_val = 4'h6;
            7'h07: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h6F: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h7C: dec_val = 4'hB;
            7'h39: dec_val = 4'hC;
            7'h5E: dec_val = 4'hD;
            7'h79: dec_val = 4'hE;
            7'h71: dec_val = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp        <= '0;
            cnt         <= '0;
            captured    <= 1'b0;
            seen        <= '0;
            bcd_out     <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            err         <= 1'b0;
            frame_valid <= 1'b0;
            samp        <= samp_in;

            if (capture) begin
                captured <= 1'b1;
                if (multi) begin
                    err <= 1'b1;
                end else if (samp_en != '0) begin
                    if (&seen_next) begin
                        frame_valid <= 1'b1;
                        seen        <= '0;
                    end else begin
                        seen <= seen_next;
                    end
                    if (!dec_legal && !dec_blank) begin
                        err <= 1'b1;
                    end
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (samp_en[i]) begin
                            if (dec_legal) begin
                                bcd_out[4*i +: 4] <= dec_val;
                                dp_out[i]         <= samp_dp;
                                digit_valid[i]    <= 1'b1;
                            end else begin
                                digit_valid[i] <= 1'b0;
                                if (dec_blank) begin
                                    dp_out[i] <= samp_dp;
                                end
                            end
                        end
                    end
                end
            end

            // A change starts a new window; placed after the capture block so
            // that clearing captured wins when both happen on the same edge.
            if (samp_in != samp) begin
                cnt      <= 8'd1;
                captured <= 1'b0;
            end else if (cnt != STB) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;

    logic [6:0]  seg_ca;
    logic        dp_ca;
    logic [3:0]  en_ca;
    logic [15:0] bcd_ca;
    logic [3:0]  dpo_ca;
    logic [3:0]  dv_ca;
    logic        fv_ca;
    logic        err_ca;

    int total  = 0;
    int passed = 0;
    int err_cnt = 0;
    int fv_cnt  = 0;
    int both_cnt = 0;
    int e0, f0, b0, fmid;

    logic [6:0] pats [4];
    logic       dps  [4];
    logic [3:0] ens  [4];

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(4), .COMMON_ANODE(1'b0), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .dig_en(dig_en),
        .bcd_out(bcd_out), .dp_out(dp_out), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .err(err)
    );

    seg7_scan_decoder #(.NUM_DIGITS(4), .COMMON_ANODE(1'b1), .STABLE_CYCLES(4)) dut_ca (
        .clk(clk), .rst(rst), .seg_in(seg_ca), .dp_in(dp_ca), .dig_en(en_ca),
        .bcd_out(bcd_ca), .dp_out(dpo_ca), .digit_valid(dv_ca),
        .frame_valid(fv_ca), .err(err_ca)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (err) err_cnt++;
            if (frame_valid) fv_cnt++;
            if (err && frame_valid) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [6:0] s, input logic d, input logic [3:0] e, input int n);
        seg_in = s;
        dp_in  = d;
        dig_en = e;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        pats[0] = 7'h4F; pats[1] = 7'h06; pats[2] = 7'h66; pats[3] = 7'h06;
        dps[0]  = 1'b0;  dps[1]  = 1'b0;  dps[2]  = 1'b1;  dps[3]  = 1'b0;
        ens[0]  = 4'b0001; ens[1] = 4'b0010; ens[2] = 4'b0100; ens[3] = 4'b1000;

        seg_ca = 7'h7F;
        dp_ca  = 1'b1;
        en_ca  = 4'hF;

        // reset with random inputs
        rst = 1'b1;
        drive(7'($urandom), 1'($urandom), 4'($urandom), 3);
        chk("rst_bcd", bcd_out, 16'h0);
        chk("rst_dp", dp_out, 4'h0);
        chk("rst_valid", digit_valid, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_ca_bcd", bcd_ca, 16'h0);

        // capture latency after release
        rst = 1'b0;
        drive(7'h5B, 1'b0, 4'b0001, 4);
        chk("lat_early_bcd", bcd_out, 16'h0);
        chk("lat_early_valid", digit_valid, 4'h0);
        drive(7'h5B, 1'b0, 4'b0001, 1);
        chk("lat_bcd", bcd_out, 16'h0002);
        chk("lat_valid", digit_valid, 4'b0001);

        // clean slate for the frame test
        rst = 1'b1;
        drive(7'h5B, 1'b0, 4'b0001, 1);
        chk("rst2_bcd", bcd_out, 16'h0);
        rst = 1'b0;

        // full frame 3,1,4,1 with dp on digit 2
        e0 = err_cnt; f0 = fv_cnt; fmid = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) fmid = fv_cnt;
            drive(pats[i], dps[i], ens[i], 8);
            drive(7'h00, 1'b0, 4'b0000, 2);
        end
        chk("frame_bcd", bcd_out, 16'h1413);
        chk("frame_dp", dp_out, 4'b0100);
        chk("frame_valid_mask", digit_valid, 4'b1111);
        chk("frame_fv_count", fv_cnt - f0, 1);
        chk("frame_fv_before_d3", fmid - f0, 0);
        chk("frame_err", err_cnt - e0, 0);

        // multiple enables held 10 cycles
        e0 = err_cnt; f0 = fv_cnt;
        drive(7'h06, 1'b0, 4'b0011, 10);
        drive(7'h00, 1'b0, 4'b0000, 2);
        chk("multi_err", err_cnt - e0, 1);
        chk("multi_bcd", bcd_out, 16'h1413);
        chk("multi_valid", digit_valid, 4'b1111);

        // digits 2 and 3 alone must not complete a frame if seen was untouched
        drive(7'h6D, 1'b0, 4'b0100, 8);
        drive(7'h00, 1'b0, 4'b0000, 2);
        drive(7'h7D, 1'b0, 4'b1000, 8);
        drive(7'h00, 1'b0, 4'b0000, 2);
        chk("d23_bcd", bcd_out, 16'h6513);
        chk("d23_dp", dp_out, 4'b0000);
        chk("multi_seen_fv", fv_cnt - f0, 0);

        // glitch rejection on digit 0
        drive(7'h7F, 1'b0, 4'b0001, 3);
        drive(7'h00, 1'b0, 4'b0000, 6);
        chk("glitch3_bcd", bcd_out, 16'h6513);
        drive(7'h7F, 1'b0, 4'b0001, 4);
        drive(7'h00, 1'b0, 4'b0000, 6);
        chk("glitch4_bcd", bcd_out, 16'h6518);
        chk("glitch_fv", fv_cnt - f0, 0);

        // illegal pattern on digit 1 completes the frame
        e0 = err_cnt; f0 = fv_cnt; b0 = both_cnt;
        drive(7'h01, 1'b1, 4'b0010, 8);
        drive(7'h00, 1'b0, 4'b0000, 2);
        chk("illegal_err", err_cnt - e0, 1);
        chk("illegal_fv", fv_cnt - f0, 1);
        chk("illegal_same_cycle", both_cnt - b0, 1);
        chk("illegal_valid", digit_valid, 4'b1101);
        chk("illegal_bcd", bcd_out, 16'h6518);
        chk("illegal_dp", dp_out, 4'b0000);

        // blank pattern on digit 1
        e0 = err_cnt;
        drive(7'h00, 1'b1, 4'b0010, 8);
        drive(7'h00, 1'b0, 4'b0000, 2);
        chk("blank_err", err_cnt - e0, 0);
        chk("blank_valid", digit_valid, 4'b1101);
        chk("blank_dp", dp_out, 4'b0010);
        chk("blank_bcd", bcd_out, 16'h6518);

        // common-anode instance
        seg_ca = ~7'h6D;
        dp_ca  = 1'b0;
        en_ca  = ~4'b0100;
        repeat (8) @(posedge clk);
        #1;
        chk("ca_bcd", bcd_ca, 16'h0500);
        chk("ca_dp", dpo_ca, 4'b0100);
        chk("ca_valid", dv_ca, 4'b0100);
        chk("ca_err", err_ca, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the BCD-to-7-segment display path.
- Monitors a multiplexed 7-segment display bus (segments, decimal point, digit enables) and recovers per-digit hex/BCD values, decimal points and validity.
- Deglitches the bus by requiring each pattern to be stable for a programmable number of cycles.
- Serves as a loopback checker behind the display driver and as a front end for capturing display contents from external panels.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (1..8).
- COMMON_ANODE, 0: 1 means seg_in, dp_in and dig_en are active-low; 0 means all are active-high.
- STABLE_CYCLES, 4: consecutive identical samples required before capture (2..255).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines {g,f,e,d,c,b,a}, bit 0 = a.
- dp_in  in  1  decimal point line.
- dig_en  in  NUM_DIGITS  digit enable lines, bit i = digit i.
- bcd_out  out  4*NUM_DIGITS  decoded value; digit i occupies bits [4i+3:4i].
- dp_out  out  NUM_DIGITS  captured decimal point per digit (active-high).
- digit_valid  out  NUM_DIGITS  1 = last capture of digit i was a legal pattern.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err  out  1  one-cycle pulse on an illegal pattern or multiple active enables.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - bcd_out=0, dp_out=0, digit_valid=0, frame_valid=0, err=0.
  - Sample register, stability counter, captured flag and seen mask all cleared.
  - Reset asserted mid-window discards partial stability; a full new window is required after release.
- Normalisation: when COMMON_ANODE=1, seg_in, dp_in and dig_en are inverted before use. All internal logic works on active-high values.
- Input stage: normalised {seg, dp, dig_en} is registered every cycle into samp (1-cycle latency).
- Stability counter:
  - Increments (saturating) while samp equals its previous-cycle value.
  - Cleared on any difference; the captured flag is cleared at the same time.
- Capture condition: samp has held one value for STABLE_CYCLES consecutive cycles and the captured flag is clear. The captured flag is then set, so each stable window captures exactly once.
- Latency: an input change held steady updates outputs STABLE_CYCLES+1 clock edges after it is first presented. With the default of 4, that is 5 edges.
- Enable decode at capture:
  - Zero enables: blanking interval. No capture, no err.
  - Exactly one enable (digit i): decode.
  - Two or more enables: err pulses once, no register update.
- Decode table (active-high {g..a} -> value), legal patterns:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
  - 0x77->A, 0x7C->b, 0x39->C, 0x5E->d, 0x79->E, 0x71->F.
- Digit i update on a single-enable capture:
  - Legal pattern: bcd_out[i] = value, dp_out[i] = dp, digit_valid[i] = 1.
  - Blank (0x00): digit_valid[i] = 0, dp_out[i] = dp, bcd_out[i] unchanged, no err.
  - Any other pattern: digit_valid[i] = 0, bcd_out[i] and dp_out[i] unchanged, err pulses.
- Frame tracking:
  - seen[i] is set on every single-enable capture of digit i, whether legal, blank or illegal.
  - When the capture that completes seen becomes all ones, frame_valid pulses in the same cycle as the output update and seen clears.
  - Re-capturing an already-seen digit has no effect on seen.
- Simultaneous events: frame_valid and err may pulse in the same cycle (an illegal last digit completes the frame).
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset behaviour: assert rst for 3 cycles with random inputs -> all outputs 0. Release, hold seg_in=0x5B, dig_en=0001 -> bcd_out[3:0]=2, digit_valid=0001 exactly 5 edges after release. No early update.
- Full frame, COMMON_ANODE=0, 8 cycles per digit, with 2 blank cycles (dig_en=0) between digits:
  - Stimulus: digits 3,1,4,1; dp on digit 2.
  - Required: bcd_out=0x1413, dp_out=0100, digit_valid=1111, one frame_valid pulse after digit 3 is captured.
- Glitch rejection: 3-cycle pulse of seg_in=0x7F on digit 0, with STABLE_CYCLES=4 -> no capture and no output change. Widening the pulse to 4 cycles -> bcd_out[3:0]=8.
- Illegal and blank patterns:
  - seg_in=0x01 on digit 1 -> err pulses one cycle, digit_valid[1]=0, bcd_out[7:4] retains its old value.
  - seg_in=0x00 -> digit_valid[1]=0, no err.
- Multiple enables: dig_en=0011 held 10 cycles -> exactly one err pulse, no digit updated, seen unchanged.
- COMMON_ANODE=1 instance: seg_in=~0x6D, dig_en=~0100, dp_in=0 -> bcd_out[11:8]=5, dp_out[2]=1, digit_valid[2]=1.
